// File: rtl/free_list.sv
// free_list: circular buffer of unallocated physical register indices for rename.
// Dispatch pops one index per cycle; ROB commit pushes stale indices back.
// Optional feature macro: FREE_LIST_FLUSH_EN adds the flush port, which refills
// the list on a branch-mispredict recovery.
module free_list #(
  parameter int unsigned  PHY_REGS  = 64,
  parameter int unsigned  ARCH_REGS = 32,
  localparam int unsigned DEPTH     = PHY_REGS - ARCH_REGS,
  localparam int unsigned IDXW      = $clog2(PHY_REGS),
  localparam int unsigned PTRW      = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alloc_valid,
  output logic            alloc_ready,
  output logic [IDXW-1:0] alloc_idx,
  input  logic            free_valid,
  input  logic [IDXW-1:0] free_idx,
`ifdef FREE_LIST_FLUSH_EN
  input  logic            flush,
`endif
  output logic [PTRW-1:0] count
);

  localparam int unsigned LOW = PTRW - 1;
`ifdef FREE_LIST_FLUSH_EN
  localparam logic [PTRW-1:0] WRAP_BIT = {1'b1, {LOW{1'b0}}};
`endif

  logic [IDXW-1:0] entry_q [DEPTH];
  logic [IDXW-1:0] entry_d [DEPTH];
  logic [PTRW-1:0] hd_q, hd_d;
  logic [PTRW-1:0] tl_q, tl_d;
  logic            empty_c;
  logic            full_c;
  logic            alloc_fire_c;
  logic            free_req_c;
  logic            free_fire_c;

  // Occupancy derived purely from the registered pointers.
  assign empty_c = (hd_q == tl_q);
  assign full_c  = (hd_q[LOW-1:0] == tl_q[LOW-1:0]) && (hd_q[PTRW-1] != tl_q[PTRW-1]);

  assign alloc_ready = !empty_c;
  assign alloc_idx   = entry_q[hd_q[LOW-1:0]];
  assign count       = tl_q - hd_q;

  // Handshakes; a flush cycle swallows both sides.
`ifdef FREE_LIST_FLUSH_EN
  assign alloc_fire_c = alloc_valid && !empty_c && !flush;
  assign free_req_c   = free_valid && (free_idx != '0) && !flush;
`else
  assign alloc_fire_c = alloc_valid && !empty_c;
  assign free_req_c   = free_valid && (free_idx != '0);
`endif
  // When full, a free is only legal if the head slot is vacated the same cycle.
  assign free_fire_c = free_req_c && (!full_c || alloc_fire_c);

  // Next-state for pointers and storage.
  always_comb begin
    hd_d    = hd_q;
    tl_d    = tl_q;
    entry_d = entry_q;
    if (alloc_fire_c) begin
      hd_d = hd_q + PTRW'(1);
    end
    if (free_fire_c) begin
      entry_d[tl_q[LOW-1:0]] = free_idx;
      tl_d                   = tl_q + PTRW'(1);
    end
`ifdef FREE_LIST_FLUSH_EN
    // Reclaim everything: head sits one full lap behind the tail.
    if (flush) begin
      hd_d = tl_q ^ WRAP_BIT;
    end
`endif
  end

  // State registers; reset leaves the list full with the non-architectural regs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd_q <= '0;
      tl_q <= {1'b1, {LOW{1'b0}}};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[i] <= IDXW'(ARCH_REGS + i);
      end
    end else begin
      hd_q    <= hd_d;
      tl_q    <= tl_d;
      entry_q <= entry_d;
    end
  end

`ifndef SYNTHESIS
  // Returning an index to a full list means an index was duplicated upstream.
  free_when_full_a: assert property (@(posedge clk) disable iff (!rst)
    !(free_req_c && full_c && !alloc_fire_c))
    else $error("free_list: free of index %0d while list is full", free_idx);
`endif

endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed vector table plus randomized traffic against a queue model.
module tb_free_list;
  localparam int unsigned PHY_REGS  = 64;
  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned DEPTH     = PHY_REGS - ARCH_REGS;
  localparam int unsigned IDXW      = 6;
  localparam int unsigned PTRW      = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [IDXW-1:0] alloc_idx;
  logic            free_valid;
  logic [IDXW-1:0] free_idx;
  logic [PTRW-1:0] count;
`ifdef FREE_LIST_FLUSH_EN
  logic            flush;
`endif

  always #5 clk = ~clk;

  free_list #(.PHY_REGS(PHY_REGS), .ARCH_REGS(ARCH_REGS)) dut (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_idx   (alloc_idx),
    .free_valid  (free_valid),
    .free_idx    (free_idx),
`ifdef FREE_LIST_FLUSH_EN
    .flush       (flush),
`endif
    .count       (count)
  );

  typedef struct {
    bit rst_before;
    bit av;
    bit fv;
    int fi;
    bit er;
    bit ci;
    int ei;
    int ec;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rb, bit av, bit fv, int fi, bit er, bit ci, int ei, int ec);
    vec_t v;
    v.rst_before = rb; v.av = av; v.fv = fv; v.fi = fi;
    v.er = er; v.ci = ci; v.ei = ei; v.ec = ec;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    free_idx    = '0;
`ifdef FREE_LIST_FLUSH_EN
    flush       = 1'b0;
`endif
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < int'(DEPTH); i++) q.push_back(int'(ARCH_REGS) + i);
  endfunction

  initial begin
    rst         = 1'b0;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    free_idx    = '0;
`ifdef FREE_LIST_FLUSH_EN
    flush       = 1'b0;
`endif

    // Drain from full: 32..63 then empty; refill with one free of 40.
    for (int i = 0; i < 32; i++) vecs.push_back(mk(i == 0, 1, 0, 0, 1, 1, 32 + i, 32 - i));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 40, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 40, 1));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 40, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    // Sustained alloc+free from full, pointers wrap and 5 comes back out.
    for (int k = 0; k < 40; k++) vecs.push_back(mk(k == 0, 1, 1, 5, 1, 1, (k < 32) ? 32 + k : 5, 32));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 5, 32));
    // free_idx 0 is dropped, both when full and when not full.
    vecs.push_back(mk(1, 0, 1, 0, 1, 1, 32, 32));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32, 32));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 32, 32));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 33, 31));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 33, 31));

    foreach (vecs[n]) begin
      if (vecs[n].rst_before) do_reset();
      @(negedge clk);
      chk($sformatf("vec%0d alloc_ready", n), int'(alloc_ready), int'(vecs[n].er));
      chk($sformatf("vec%0d count", n), int'(count), vecs[n].ec);
      if (vecs[n].ci) chk($sformatf("vec%0d alloc_idx", n), int'(alloc_idx), vecs[n].ei);
      alloc_valid = vecs[n].av;
      free_valid  = vecs[n].fv;
      free_idx    = IDXW'(vecs[n].fi);
    end
    @(negedge clk);
    alloc_valid = 1'b0;
    free_valid  = 1'b0;

    // Asynchronous reset mid-stream with count 7, observed before the next edge.
    do_reset();
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1;
    end
    @(negedge clk);
    alloc_valid = 1'b0;
    chk("pre_async count", int'(count), 7);
    chk("pre_async alloc_idx", int'(alloc_idx), 57);
    #2 rst = 1'b0;
    #1;
    chk("async alloc_ready", int'(alloc_ready), 1);
    chk("async alloc_idx", int'(alloc_idx), 32);
    chk("async count", int'(count), 32);
    @(negedge clk);
    rst = 1'b1;

`ifdef FREE_LIST_FLUSH_EN
    // Flush overrides a same-cycle alloc and free and refills the list.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1;
    end
    @(negedge clk);
    alloc_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      free_valid = 1'b1;
      free_idx   = IDXW'(i);
      @(negedge clk);
    end
    free_valid = 1'b0;
    chk("pre_flush count", int'(count), 25);
    flush       = 1'b1;
    alloc_valid = 1'b1;
    free_valid  = 1'b1;
    free_idx    = IDXW'(9);
    @(negedge clk);
    flush       = 1'b0;
    alloc_valid = 1'b0;
    free_valid  = 1'b0;
    chk("flush count", int'(count), 32);
    chk("flush alloc_ready", int'(alloc_ready), 1);
    @(negedge clk);
    chk("post_flush count", int'(count), 32);
`endif

    // Random traffic against the queue model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit av, fv, af, ff;
      int fi;
      @(negedge clk);
      chk($sformatf("rnd%0d alloc_ready", c), int'(alloc_ready), int'(q.size() > 0));
      chk($sformatf("rnd%0d count", c), int'(count), q.size());
      if (q.size() > 0) chk($sformatf("rnd%0d alloc_idx", c), int'(alloc_idx), q[0]);
      av = bit'($urandom_range(0, 1));
      fv = bit'($urandom_range(0, 1));
      fi = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63));
      af = av && (q.size() > 0);
      if (fv && fi != 0 && q.size() == int'(DEPTH) && !af) fv = 1'b0;
      ff = fv && (fi != 0);
      alloc_valid = av;
      free_valid  = fv;
      free_idx    = IDXW'(fi);
      if (af) void'(q.pop_front());
      if (ff) q.push_back(fi);
    end
    @(negedge clk);
    alloc_valid = 1'b0;
    free_valid  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
